mdio_controller: RTL

//  Station-management (MAC-side) MDIO transaction generator. Upstream neighbour of the PHY-side MDIO receiver.

---
 rtl/mdio_pkg.sv | 43 ++++
 rtl/mdio_shifter.sv | 47 ++++
 rtl/mdio_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame field positions, opcodes, widths and controller state encodings.
// Used by both the MAC-side controller and the PHY-side receiver.
package mdio_pkg;

    localparam int FRAME_W = 32;
    localparam int DATA_W  = 16;
    localparam int PRE_W   = 32;
    localparam int CNT_W   = 5;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_SOF   = 2'b01;

    localparam int ST_HI   = 31;
    localparam int ST_LO   = 30;
    localparam int OP_HI   = 29;
    localparam int OP_LO   = 28;
    localparam int PHY_HI  = 27;
    localparam int PHY_LO  = 23;
    localparam int REG_HI  = 22;
    localparam int REG_LO  = 18;
    localparam int TA_HI   = 17;
    localparam int TA_LO   = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PREAMBLE  = 2'd1,
        S_SHIFT_OUT = 2'd2,
        S_READ_IN   = 2'd3
    } mdio_state_t;

    function automatic logic frame_valid(input logic [FRAME_W-1:0] f);
        return (f[ST_HI:ST_LO] == ST_SOF) &&
               ((f[OP_HI:OP_LO] == OP_WRITE) || (f[OP_HI:OP_LO] == OP_READ));
    endfunction

    function automatic logic frame_is_read(input logic [FRAME_W-1:0] f);
        return f[OP_HI:OP_LO] == OP_READ;
    endfunction

endpackage

// File: rtl/mdio_shifter.sv
// Datapath for the MDIO controller: loadable MSB-first PISO, MSB-first SIPO and the phase bit counter.
module mdio_shifter
    import mdio_pkg::*;
(
    input  logic               MDC,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               shift,
    input  logic               sample,
    input  logic               sdi,
    input  logic               cnt_clr,
    input  logic               cnt_inc,
    output logic               sdo,
    output logic [DATA_W-1:0]  sipo_next,
    output logic [CNT_W-1:0]   cnt
);

    logic [FRAME_W-1:0] piso;
    logic [DATA_W-2:0]  sipo;

    assign sdo       = piso[FRAME_W-1];
    // Includes the bit being sampled this edge, so the last sample can be captured directly.
    assign sipo_next = {sipo, sdi};

    always_ff @(posedge MDC or negedge reset) begin
        if (!reset) begin
            piso <= '0;
            sipo <= '0;
            cnt  <= '0;
        end else begin
            if (load)
                piso <= load_data;
            else if (shift)
                piso <= {piso[FRAME_W-2:0], 1'b0};

            if (sample)
                sipo <= sipo_next[DATA_W-2:0];

            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdio_controller.sv
// MAC-side MDIO transaction generator: serialises a 32-bit frame, captures 16 read bits.
// Optional preamble phase enabled by defining MDIO_PREAMBLE_EN.
//
// state       | meaning
// S_IDLE      | waiting for START; also clears BUSY after a dropped frame
// S_PREAMBLE  | driving PRE_W ones before the frame (MDIO_PREAMBLE_EN only)
// S_SHIFT_OUT | driving frame bits MSB first (32 for write, 16 for read)
// S_READ_IN   | line released, sampling 16 data bits from MDIO_IN
module mdio_controller
    import mdio_pkg::*;
(
    input  logic               MDC,
    input  logic               reset,
    input  logic               MDIO_START,
    input  logic [FRAME_W-1:0] T_DATA,
    input  logic               MDIO_IN,
    output logic               MDIO_OUT,
    output logic               MDIO_OE,
    output logic [DATA_W-1:0]  RD_DATA,
    output logic               DATA_RDY,
    output logic               BUSY
);

    localparam logic [CNT_W-1:0] LAST_WR_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_RD_BIT = CNT_W'(FRAME_W - DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(DATA_W - 1);
`ifdef MDIO_PREAMBLE_EN
    localparam logic [CNT_W-1:0] LAST_PRE    = CNT_W'(PRE_W - 1);
`endif

    mdio_state_t        state, state_nxt;
    logic               is_read, is_read_nxt;
    logic               out_nxt, oe_nxt, busy_nxt, rdy_nxt;
    logic [DATA_W-1:0]  rd_nxt;

    logic               load, shift, sample, cnt_clr, cnt_inc, sdo;
    logic [FRAME_W-1:0] load_data;
    logic [DATA_W-1:0]  sipo_next;
    logic [CNT_W-1:0]   cnt;

    mdio_shifter u_shifter (
        .MDC       (MDC),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .shift     (shift),
        .sample    (sample),
        .sdi       (MDIO_IN),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .sdo       (sdo),
        .sipo_next (sipo_next),
        .cnt       (cnt)
    );

    always_ff @(posedge MDC or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            is_read  <= 1'b0;
            MDIO_OUT <= 1'b0;
            MDIO_OE  <= 1'b0;
            BUSY     <= 1'b0;
            DATA_RDY <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            state    <= state_nxt;
            is_read  <= is_read_nxt;
            MDIO_OUT <= out_nxt;
            MDIO_OE  <= oe_nxt;
            BUSY     <= busy_nxt;
            DATA_RDY <= rdy_nxt;
            RD_DATA  <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        is_read_nxt = is_read;
        out_nxt     = MDIO_OUT;
        oe_nxt      = MDIO_OE;
        busy_nxt    = BUSY;
        rdy_nxt     = 1'b0;
        rd_nxt      = RD_DATA;
        load        = 1'b0;
        load_data   = '0;
        shift       = 1'b0;
        sample      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        case (state)
            S_IDLE: begin
                // BUSY still high here means the previous START was a dropped frame.
                if (BUSY) begin
                    busy_nxt = 1'b0;
                end else if (MDIO_START) begin
                    busy_nxt = 1'b1;
                    if (frame_valid(T_DATA)) begin
                        is_read_nxt = frame_is_read(T_DATA);
                        load        = 1'b1;
                        cnt_clr     = 1'b1;
                        oe_nxt      = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                        out_nxt     = 1'b1;
                        load_data   = T_DATA;
                        state_nxt   = S_PREAMBLE;
`else
                        out_nxt     = T_DATA[FRAME_W-1];
                        load_data   = {T_DATA[FRAME_W-2:0], 1'b0};
                        state_nxt   = S_SHIFT_OUT;
`endif
                    end
                end
            end
`ifdef MDIO_PREAMBLE_EN
            S_PREAMBLE: begin
                if (cnt == LAST_PRE) begin
                    out_nxt   = sdo;
                    shift     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_SHIFT_OUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            S_SHIFT_OUT: begin
                if (cnt == (is_read ? LAST_RD_BIT : LAST_WR_BIT)) begin
                    oe_nxt  = 1'b0;
                    out_nxt = 1'b0;
                    cnt_clr = 1'b1;
                    if (is_read) begin
                        state_nxt = S_READ_IN;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    out_nxt = sdo;
                    shift   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            S_READ_IN: begin
                sample  = 1'b1;
                cnt_inc = 1'b1;
                if (cnt == LAST_SAMPLE) begin
                    rd_nxt    = sipo_next;
                    rdy_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
